// File: rtl/demux_regbank_mux.sv
// rtl/demux_regbank_mux.sv - flat-vector read mux selecting one width-bit entry of 2**selbits
module demux_regbank_mux #(
   parameter int selbits = 3,
   parameter int width   = 8
) (
   input  logic [(2**selbits)*width-1:0] data,
   input  logic [selbits-1:0]            sel,
   output logic [width-1:0]              q
);

   localparam int n = 2**selbits;

   always_comb begin
      q = '0;
      for (int i = 0; i < n; i++) begin
         if (sel == selbits'(i)) q = data[i*width +: width];
      end
   end

endmodule

// File: rtl/demux_regbank.sv
// rtl/demux_regbank.sv - write demux into 2**selbits registers via a one-entry pending stage with read bypass
module demux_regbank #(
   parameter int selbits = 3,
   parameter int width   = 8
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          wr_valid,
   output logic                          wr_ready,
   input  logic [selbits-1:0]            wr_sel,
   input  logic [width-1:0]              wr_data,
   input  logic                          hold,
   input  logic                          clr_valid,
   input  logic [selbits-1:0]            rd_sel,
   output logic [width-1:0]              rd_data,
   output logic                          rd_hit,
   output logic [(2**selbits)-1:0]       valid_map,
   output logic [(2**selbits)*width-1:0] out_flat
);

   localparam int n = 2**selbits;

   logic [width-1:0]   entry [n];
   logic [n-1:0]       valid_q;
   logic [n-1:0]       valid_next;
   logic               pend_vld;
   logic [selbits-1:0] pend_sel;
   logic [width-1:0]   pend_data;
   logic               accept;
   logic               commit;
   logic [width-1:0]   entry_rd;

   assign wr_ready = !reset && (!pend_vld || !hold);
   assign accept   = wr_valid && wr_ready;
   assign commit   = pend_vld && !hold;

   // A commit on the same edge as clr_valid keeps its own valid bit.
   always_comb begin
      valid_next = clr_valid ? '0 : valid_q;
      if (commit) valid_next[pend_sel] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < n; i++) entry[i] <= '0;
         valid_q   <= '0;
         pend_vld  <= 1'b0;
         pend_sel  <= '0;
         pend_data <= '0;
      end else begin
         valid_q <= valid_next;
         if (commit) entry[pend_sel] <= pend_data;
         if (accept) begin
            pend_vld  <= 1'b1;
            pend_sel  <= wr_sel;
            pend_data <= wr_data;
         end else if (commit) begin
            pend_vld <= 1'b0;
         end
      end
   end

   always_comb begin
      out_flat = '0;
      for (int i = 0; i < n; i++) out_flat[i*width +: width] = entry[i];
   end

   assign valid_map = valid_q;

   demux_regbank_mux #(
      .selbits(selbits),
      .width  (width)
   ) u_rd_mux (
      .data(out_flat),
      .sel (rd_sel),
      .q   (entry_rd)
   );

   // Pending write shadows the committed entry on the read port only.
   always_comb begin
      if (pend_vld && pend_sel == rd_sel) begin
         rd_data = pend_data;
         rd_hit  = 1'b1;
      end else begin
         rd_data = entry_rd;
         rd_hit  = valid_q[rd_sel];
      end
   end

endmodule

// File: tb/tb_demux_regbank.sv
// tb/tb_demux_regbank.sv - table-driven bench for demux_regbank
module tb_demux_regbank;

   logic        clk = 1'b0;
   logic        reset;
   logic        wr_valid;
   logic        wr_ready;
   logic [2:0]  wr_sel;
   logic [7:0]  wr_data;
   logic        hold;
   logic        clr_valid;
   logic [2:0]  rd_sel;
   logic [7:0]  rd_data;
   logic        rd_hit;
   logic [7:0]  valid_map;
   logic [63:0] out_flat;

   demux_regbank #(.selbits(3), .width(8)) dut (
      .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .wr_sel(wr_sel), .wr_data(wr_data), .hold(hold), .clr_valid(clr_valid),
      .rd_sel(rd_sel), .rd_data(rd_data), .rd_hit(rd_hit),
      .valid_map(valid_map), .out_flat(out_flat)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic       wv;
      logic [2:0] ws;
      logic [7:0] wd;
      logic       hld;
      logic       clr;
      logic [2:0] rs;
      logic       e_ready;
      logic [7:0] e_rd;
      logic       e_hit;
      logic [7:0] e_vmap;
      logic [2:0] fs;
      logic [7:0] e_flat;
   } vec_t;

   vec_t vecs[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic add(input logic rst, input logic wv, input logic [2:0] ws, input logic [7:0] wd,
                      input logic hld, input logic clr, input logic [2:0] rs, input logic e_ready,
                      input logic [7:0] e_rd, input logic e_hit, input logic [7:0] e_vmap,
                      input logic [2:0] fs, input logic [7:0] e_flat);
      vec_t v;
      v = '{rst, wv, ws, wd, hld, clr, rs, e_ready, e_rd, e_hit, e_vmap, fs, e_flat};
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   initial begin
      reset = 1'b1; wr_valid = 1'b0; wr_sel = '0; wr_data = '0;
      hold = 1'b0; clr_valid = 1'b0; rd_sel = '0;

      //   rst wv ws  wd     hld clr rs  rdy rd     hit vmap   fs  flat
      // single write to 5
      add(0, 1, 5, 8'hA7, 0, 0, 5, 1, 8'h00, 0, 8'h00, 5, 8'h00);
      add(0, 0, 0, 8'h00, 0, 0, 5, 1, 8'hA7, 1, 8'h00, 5, 8'h00);
      add(0, 0, 0, 8'h00, 0, 0, 5, 1, 8'hA7, 1, 8'h20, 5, 8'hA7);
      // back-to-back 0..7
      add(0, 1, 0, 8'h10, 0, 0, 0, 1, 8'h00, 0, 8'h20, 5, 8'hA7);
      add(0, 1, 1, 8'h11, 0, 0, 0, 1, 8'h10, 1, 8'h20, 5, 8'hA7);
      add(0, 1, 2, 8'h12, 0, 0, 1, 1, 8'h11, 1, 8'h21, 0, 8'h10);
      add(0, 1, 3, 8'h13, 0, 0, 2, 1, 8'h12, 1, 8'h23, 1, 8'h11);
      add(0, 1, 4, 8'h14, 0, 0, 3, 1, 8'h13, 1, 8'h27, 2, 8'h12);
      add(0, 1, 5, 8'h15, 0, 0, 4, 1, 8'h14, 1, 8'h2F, 3, 8'h13);
      add(0, 1, 6, 8'h16, 0, 0, 5, 1, 8'h15, 1, 8'h3F, 4, 8'h14);
      add(0, 1, 7, 8'h17, 0, 0, 6, 1, 8'h16, 1, 8'h3F, 5, 8'h15);
      add(0, 0, 0, 8'h00, 0, 0, 7, 1, 8'h17, 1, 8'h7F, 6, 8'h16);
      add(0, 0, 0, 8'h00, 0, 1, 5, 1, 8'h15, 1, 8'hFF, 7, 8'h17);
      // stall: pending 2, held 3 cycles while a second write waits
      add(0, 1, 2, 8'h3C, 0, 0, 2, 1, 8'h12, 0, 8'h00, 2, 8'h12);
      add(0, 1, 3, 8'h99, 1, 0, 2, 0, 8'h3C, 1, 8'h00, 2, 8'h12);
      add(0, 1, 3, 8'h99, 1, 0, 2, 0, 8'h3C, 1, 8'h00, 2, 8'h12);
      add(0, 1, 3, 8'h99, 1, 0, 2, 0, 8'h3C, 1, 8'h00, 2, 8'h12);
      add(0, 1, 3, 8'h99, 0, 0, 2, 1, 8'h3C, 1, 8'h00, 2, 8'h12);
      add(0, 0, 0, 8'h00, 0, 0, 3, 1, 8'h99, 1, 8'h04, 2, 8'h3C);
      add(0, 0, 0, 8'h00, 0, 0, 3, 1, 8'h99, 1, 8'h0C, 3, 8'h99);
      // clear vs commit
      add(0, 1, 1, 8'h5A, 0, 0, 1, 1, 8'h11, 0, 8'h0C, 1, 8'h11);
      add(0, 1, 4, 8'h44, 0, 0, 1, 1, 8'h5A, 1, 8'h0C, 1, 8'h11);
      add(0, 0, 0, 8'h00, 0, 0, 4, 1, 8'h44, 1, 8'h0E, 1, 8'h5A);
      add(0, 1, 4, 8'h4B, 0, 0, 4, 1, 8'h44, 1, 8'h1E, 4, 8'h44);
      add(0, 0, 0, 8'h00, 0, 1, 1, 1, 8'h5A, 1, 8'h1E, 4, 8'h44);
      add(0, 0, 0, 8'h00, 0, 0, 1, 1, 8'h5A, 0, 8'h10, 4, 8'h4B);
      // accept under hold with empty stage, then overwrite with bypass
      add(0, 1, 6, 8'h11, 1, 0, 6, 1, 8'h16, 0, 8'h10, 6, 8'h16);
      add(0, 0, 0, 8'h00, 1, 0, 6, 0, 8'h11, 1, 8'h10, 6, 8'h16);
      add(0, 0, 0, 8'h00, 0, 0, 6, 1, 8'h11, 1, 8'h10, 6, 8'h16);
      add(0, 1, 6, 8'h22, 0, 0, 6, 1, 8'h11, 1, 8'h50, 6, 8'h11);
      add(0, 0, 0, 8'h00, 0, 0, 6, 1, 8'h22, 1, 8'h50, 6, 8'h11);
      add(0, 0, 0, 8'h00, 0, 0, 6, 1, 8'h22, 1, 8'h50, 6, 8'h22);
      // reset while a held write is pending
      add(0, 1, 3, 8'hFF, 0, 0, 3, 1, 8'h99, 0, 8'h50, 3, 8'h99);
      add(0, 0, 0, 8'h00, 1, 0, 3, 0, 8'hFF, 1, 8'h50, 3, 8'h99);
      add(1, 1, 0, 8'h77, 1, 1, 3, 0, 8'hFF, 1, 8'h50, 3, 8'h99);
      add(0, 0, 0, 8'h00, 0, 0, 3, 1, 8'h00, 0, 8'h00, 3, 8'h00);
      add(0, 0, 0, 8'h00, 0, 0, 3, 1, 8'h00, 0, 8'h00, 3, 8'h00);

      // reset state after the first reset edge
      @(negedge clk); #1;
      check("reset_ready", {63'd0, wr_ready}, 64'd0);
      check("reset_vmap", {56'd0, valid_map}, 64'd0);
      check("reset_flat", out_flat, 64'd0);
      check("reset_hit", {63'd0, rd_hit}, 64'd0);

      foreach (vecs[k]) begin
         @(negedge clk);
         reset = vecs[k].rst; wr_valid = vecs[k].wv; wr_sel = vecs[k].ws;
         wr_data = vecs[k].wd; hold = vecs[k].hld; clr_valid = vecs[k].clr;
         rd_sel = vecs[k].rs;
         #1;
         check($sformatf("v%0d_ready", k), {63'd0, wr_ready}, {63'd0, vecs[k].e_ready});
         check($sformatf("v%0d_rd_data", k), {56'd0, rd_data}, {56'd0, vecs[k].e_rd});
         check($sformatf("v%0d_rd_hit", k), {63'd0, rd_hit}, {63'd0, vecs[k].e_hit});
         check($sformatf("v%0d_vmap", k), {56'd0, valid_map}, {56'd0, vecs[k].e_vmap});
         check($sformatf("v%0d_flat", k), {56'd0, out_flat[vecs[k].fs*8 +: 8]}, {56'd0, vecs[k].e_flat});
         if (k == 2) check("single_write_flat", out_flat, 64'h0000_A700_0000_0000);
         if (k == 12) check("b2b_flat", out_flat, 64'h1716_1514_1312_1110);
      end

      @(negedge clk); #1;
      check("final_flat", out_flat, 64'd0);
      check("final_vmap", {56'd0, valid_map}, 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
